key_unwarm: RTL and testbench

// Inverse AES-128 key schedule for the decryptor: serves round keys 10 down to 0, one step per request.
// - On key_load, latches the cipher key and forward-expands it for NUM_ROUNDS cycles to reach round key 10.
// - It then walks the schedule backwards, computing round r-1 from round r.
// - It keeps a shadow copy of round key 10, so each new block decrypted under the same key restarts in one cycle.

---
 rtl/aes_model_pack.sv | 61 ++++++
 rtl/key_unwarm_inv_step.sv | 20 ++
 rtl/key_unwarm.sv | 128 ++++++++++++
 tb/tb_key_unwarm.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_model_pack.sv
// Shared AES-128 model definitions: byte/column layout, S-box, round constants,
// plus the column helpers and FSM state type used by the inverse key schedule.
package aes_model_pack;

  localparam int ROUND_COUNT          = 10;
  localparam int COLUMN_COUNT         = 4;
  localparam int COLUMN_SIZE_IN_BYTES = 4;

  // One key word; byte [COLUMN_SIZE_IN_BYTES-1] is the first (most significant) byte.
  typedef logic [COLUMN_SIZE_IN_BYTES-1:0][7:0] column_t;
  // Full 128-bit state; index [COLUMN_COUNT-1] holds word w0, so the packed
  // value reads in FIPS-197 byte order, MSB first.
  typedef logic [COLUMN_COUNT-1:0][COLUMN_SIZE_IN_BYTES-1:0][7:0] byte_table;

  typedef enum logic [1:0] {KU_IDLE, KU_EXPAND, KU_SERVE} key_unwarm_state_t;

  localparam logic [7:0] SUB_BYTES_TABLE [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Round constants as full columns: rcon byte sits in the first key byte.
  localparam column_t RCON_TABLE [ROUND_COUNT] = '{
    32'h01000000, 32'h02000000, 32'h04000000, 32'h08000000, 32'h10000000,
    32'h20000000, 32'h40000000, 32'h80000000, 32'h1b000000, 32'h36000000
  };

  // First byte moves to the end of the word.
  function automatic column_t rot_word(input column_t c);
    return {c[COLUMN_SIZE_IN_BYTES-2:0], c[COLUMN_SIZE_IN_BYTES-1]};
  endfunction

  function automatic column_t sub_word(input column_t c);
    column_t r;
    for (int i = 0; i < COLUMN_SIZE_IN_BYTES; i++) r[i] = SUB_BYTES_TABLE[c[i]];
    return r;
  endfunction

  // Bounded table read; out-of-range indices yield zero rather than X.
  function automatic column_t rcon_col(input logic [3:0] idx);
    column_t r;
    r = '0;
    if (int'(idx) < ROUND_COUNT) r = RCON_TABLE[idx];
    return r;
  endfunction

endpackage

// File: rtl/key_unwarm_inv_step.sv
// One inverse AES-128 key-schedule step: round key r -> round key r-1.
// Purely combinational so the decryptor datapath can reuse it.
module key_inv_step
  import aes_model_pack::*;
(
  input  byte_table round_key_in,
  input  column_t   rcon,
  output byte_table round_key_out
);

  // Undo the chained XORs from w3 down, then rebuild w0 from the recovered w3.
  always_comb begin
    round_key_out    = '0;
    round_key_out[0] = round_key_in[0] ^ round_key_in[1];
    round_key_out[1] = round_key_in[1] ^ round_key_in[2];
    round_key_out[2] = round_key_in[2] ^ round_key_in[3];
    round_key_out[3] = round_key_in[3] ^ sub_word(rot_word(round_key_out[0])) ^ rcon;
  end

endmodule

// File: rtl/key_unwarm.sv
// Inverse AES-128 key schedule: forward-expands a loaded key to round 10, then
// serves round keys 10 down to 0 one step at a time. A shadow of round 10 lets
// each new block under the same key restart in a single cycle.
module key_unwarm
  import aes_model_pack::*;
#(
  parameter int NUM_ROUNDS = ROUND_COUNT
) (
  input  logic        clk,
  input  logic        rst,
  input  byte_table   key,
  input  logic        key_load,
  input  logic        rewind,
  input  logic        round_step,
  output logic        busy,
  output logic        key_valid,
  output byte_table   round_key,
  output logic [3:0]  round_idx,
  output logic        last_round
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);
  localparam logic [3:0] LAST_CNT = 4'(NUM_ROUNDS - 1);

  key_unwarm_state_t state_q, state_d;
  byte_table         work_q, work_d;
  byte_table         shadow_q, shadow_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;

  byte_table         fwd_key;
  byte_table         inv_key;
  column_t           inv_rcon;

  // Forward step into round cnt+1; the rcon index is simply cnt.
  always_comb begin
    fwd_key    = '0;
    fwd_key[3] = work_q[3] ^ sub_word(rot_word(work_q[0])) ^ rcon_col(cnt_q);
    fwd_key[2] = work_q[2] ^ fwd_key[3];
    fwd_key[1] = work_q[1] ^ fwd_key[2];
    fwd_key[0] = work_q[0] ^ fwd_key[1];
  end

  // Stepping back from round r uses rcon[r-1]; idx 0 never steps, so pin it to 0.
  always_comb begin
    inv_rcon = '0;
    if (idx_q != 4'd0) inv_rcon = rcon_col(idx_q - 4'd1);
  end

  key_inv_step u_inv (
    .round_key_in  (work_q),
    .rcon          (inv_rcon),
    .round_key_out (inv_key)
  );

  // Next-state: key_load overrides everything; rewind beats round_step in SERVE.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    valid_d  = valid_q;
    if (key_load) begin
      work_d  = key;
      cnt_d   = 4'd0;
      idx_d   = 4'd0;
      valid_d = 1'b0;
      busy_d  = 1'b1;
      state_d = KU_EXPAND;
    end else begin
      case (state_q)
        KU_EXPAND: begin
          work_d = fwd_key;
          cnt_d  = cnt_q + 4'd1;
          if (cnt_q == LAST_CNT) begin
            shadow_d = fwd_key;
            idx_d    = LAST_IDX;
            busy_d   = 1'b0;
            valid_d  = 1'b1;
            state_d  = KU_SERVE;
          end
        end
        KU_SERVE: begin
          if (rewind) begin
            work_d = shadow_q;
            idx_d  = LAST_IDX;
          end else if (round_step && idx_q != 4'd0) begin
            work_d = inv_key;
            idx_d  = idx_q - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= KU_IDLE;
      work_q   <= '0;
      shadow_q <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  assign busy       = busy_q;
  assign key_valid  = valid_q;
  assign round_key  = work_q;
  assign round_idx  = idx_q;
  assign last_round = valid_q && (idx_q == 4'd0);

endmodule

// File: tb/tb_key_unwarm.sv
// Bench for key_unwarm: directed FIPS-197 A.1 cases plus a random-key
// scoreboard against a GF(2^8)-derived full key-expansion model.
module tb_key_unwarm;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] key_in = '0;
  logic         key_load = 1'b0, rewind = 1'b0, round_step = 1'b0;
  logic         busy, key_valid, last_round;
  logic [127:0] rk_o;
  logic [3:0]   round_idx;

  int errs = 0;
  int checks = 0;

  localparam logic [127:0] A1_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic [7:0] sb [256];

  key_unwarm dut (
    .clk(clk), .rst(rst), .key(key_in), .key_load(key_load), .rewind(rewind),
    .round_step(round_step), .busy(busy), .key_valid(key_valid),
    .round_key(rk_o), .round_idx(round_idx), .last_round(last_round)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Plain FIPS-197 expansion into 44 words; round key r = w[4r..4r+3].
  function automatic logic [127:0] model_rk(input logic [127:0] k, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [127:0] k);
    key_in = k;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
  endtask

  // Counts cycles from the load edge until key_valid, and busy cycles seen.
  task automatic wait_valid(input string tag);
    int n = 0;
    int nb = 0;
    while (!key_valid && n < 20) begin
      if (busy) nb++;
      tick();
      n++;
    end
    chk({tag, "_lat"}, 128'(n), 128'd10);
    chk({tag, "_busy_cyc"}, 128'(nb), 128'd10);
  endtask

  task automatic step();
    round_step = 1'b1;
    tick();
    round_step = 1'b0;
  endtask

  initial begin
    logic [127:0] rkey;
    int idx;
    int op;

    build_sbox();
    #12;
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_valid", 128'(key_valid), 128'd0);
    chk("rst_idx", 128'(round_idx), 128'd0);
    chk("rst_key", rk_o, 128'd0);
    rst = 1'b1;
    tick();

    // Expansion of A.1 key, with round_step held high throughout (must be ignored).
    load(A1_KEY);
    chk("exp_busy0", 128'(busy), 128'd1);
    chk("exp_valid0", 128'(key_valid), 128'd0);
    round_step = 1'b1;
    wait_valid("a1");
    round_step = 1'b0;
    chk("a1_idx10", 128'(round_idx), 128'd10);
    chk("a1_rk10", rk_o, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("a1_busy_lo", 128'(busy), 128'd0);

    // Inverse walk.
    step();
    chk("walk_idx9", 128'(round_idx), 128'd9);
    chk("walk_rk9", rk_o, 128'hac7766f319fadc2128d12941575c006e);
    for (int i = 0; i < 8; i++) step();
    chk("walk_idx1", 128'(round_idx), 128'd1);
    chk("walk_rk1", rk_o, 128'ha0fafe1788542cb123a339392a6c7605);
    chk("walk_last1", 128'(last_round), 128'd0);
    step();
    chk("walk_idx0", 128'(round_idx), 128'd0);
    chk("walk_rk0", rk_o, A1_KEY);
    chk("walk_last0", 128'(last_round), 128'd1);

    // Steps at idx 0 are ignored.
    for (int i = 0; i < 3; i++) step();
    chk("hold_idx0", 128'(round_idx), 128'd0);
    chk("hold_rk0", rk_o, A1_KEY);

    rewind = 1'b1;
    tick();
    rewind = 1'b0;
    chk("rew_idx", 128'(round_idx), 128'd10);
    chk("rew_rk", rk_o, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("rew_busy", 128'(busy), 128'd0);

    // rewind beats round_step at idx 5.
    for (int i = 0; i < 5; i++) step();
    chk("pri_idx5", 128'(round_idx), 128'd5);
    chk("pri_rk5", rk_o, model_rk(A1_KEY, 5));
    rewind = 1'b1;
    round_step = 1'b1;
    tick();
    rewind = 1'b0;
    round_step = 1'b0;
    chk("pri_rew_idx", 128'(round_idx), 128'd10);
    chk("pri_rew_rk", rk_o, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // key_load wins over rewind in SERVE, then abort at EXPAND cycle 4.
    key_in = A1_KEY;
    key_load = 1'b1;
    rewind = 1'b1;
    tick();
    key_load = 1'b0;
    rewind = 1'b0;
    chk("kl_rew_busy", 128'(busy), 128'd1);
    chk("kl_rew_valid", 128'(key_valid), 128'd0);
    for (int i = 0; i < 4; i++) tick();
    load(128'h0);
    wait_valid("abort");
    chk("abort_rk10", rk_o, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    chk("abort_idx", 128'(round_idx), 128'd10);
    rewind = 1'b1;
    tick();
    rewind = 1'b0;
    chk("abort_shadow", rk_o, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // Asynchronous reset mid-SERVE.
    step();
    step();
    #3;
    rst = 1'b0;
    #1;
    chk("arst_busy", 128'(busy), 128'd0);
    chk("arst_valid", 128'(key_valid), 128'd0);
    chk("arst_idx", 128'(round_idx), 128'd0);
    chk("arst_rk", rk_o, 128'd0);
    tick();
    rst = 1'b1;
    tick();

    // Random keys and random step/rewind traffic against the model.
    for (int k = 0; k < 6; k++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      load(rkey);
      wait_valid("rnd");
      idx = 10;
      chk("rnd_rk10", rk_o, model_rk(rkey, 10));
      for (int j = 0; j < 30; j++) begin
        op = int'($urandom_range(0, 99));
        if (op < 70) begin
          step();
          if (idx > 0) idx--;
        end else if (op < 85) begin
          rewind = 1'b1;
          round_step = $urandom_range(0, 1) == 1;
          tick();
          rewind = 1'b0;
          round_step = 1'b0;
          idx = 10;
        end else begin
          tick();
        end
        chk("rnd_idx", 128'(round_idx), 128'(idx));
        chk("rnd_rk", rk_o, model_rk(rkey, idx));
        chk("rnd_last", 128'(last_round), 128'(idx == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
